axi_byte_io_master: RTL and testbench
=====================================

# axi_byte_io_master

Single-byte DMA engine: one `start` pulse performs one byte read from, or one byte write to, a 32-bit byte address in system memory, using an AXI4-Lite master port with a 64-bit data bus. It sits between the channel data streams (send/receive bytes) and the memory interconnect. Its controller issues one transfer per channel byte and waits for `done`.

## Interface
- Parameters: none.
- `aclk` in 1: clock; all logic on its rising edge.
- `aresetn` in 1: synchronous, active-low reset.
- `busy` out 1: transfer in progress.
- `write` in 1: direction. 1 writes `data_write` to memory; 0 reads a memory byte into `data_read`. Sampled on the start cycle.
- `addr` in 32: byte address, sampled on the start cycle.
- `data_read` out 8: byte returned by the last completed read.
- `data_write` in 8: byte to write, sampled on the start cycle.
- `start` in 1: one-cycle request; honoured only when `busy`=0.
- `done` out 1: one-cycle completion pulse.
- `m_axi_araddr` out 32, `m_axi_arvalid` out 1, `m_axi_arready` in 1: read address channel.
- `m_axi_rdata` in 64, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: read data channel.
- `m_axi_awaddr` out 32, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write address channel.
- `m_axi_wdata` out 64, `m_axi_wstrb` out 8, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write response channel.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - `start`=1 captures `addr`, `write` and `data_write`.
  - Then goes to RD_ADDR if `write`=0, or WR_REQ if `write`=1.
- Lane selection:
  - `lane` = captured `addr[2:0]`.
  - Bus address = `{addr[31:3],3'b000}` on both AR and AW.
- RD_ADDR: `arvalid`=1. On `arready`, `arvalid` drops and the state goes to RD_DATA.
- RD_DATA:
  - `rready`=1.
  - On `rvalid`: `data_read` <= `rdata[8*lane+7 : 8*lane]`, `rready` drops, `done` pulses, state goes to IDLE.
- WR_REQ:
  - `awvalid`=1 and `wvalid`=1 together.
  - `wdata` = captured byte replicated in all 8 lanes; `wstrb` = `8'b1 << lane`.
  - Each valid drops independently on its own handshake. Once both are accepted (same or different cycles), go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, `bready` drops, `done` pulses, state goes to IDLE.
- `rresp`/`bresp` are ignored. Error responses still complete normally with `done`; the read byte is captured regardless.
- `busy`=1 in every state except IDLE.
- `data_read` holds its value until the next read completes. Writes never change it.
- `start` while `busy`=1 is ignored.
- Idle bus outputs: `araddr`/`awaddr` = last captured aligned address (0 after reset); `wdata`/`wstrb` = last values (0 after reset).

## Timing
- Reset values: `busy`=0, `done`=0, `data_read`=0, all valids and readies 0, addresses, `wdata` and `wstrb` 0, state IDLE.
- Reset mid-transfer aborts immediately: no `done`, valids drop the next cycle.
- Cycle S = `start` sampled in IDLE. In S+1, `busy`=1 and `arvalid` (or `awvalid`+`wvalid`) is asserted.
- Valids stay high and stable until their handshake (AXI rule).
- Read: handshake cycle A leads to `rready`=1 at A+1. `rvalid` at cycle R gives `done`=1, `busy`=0 and the new `data_read` at R+1.
- Write: the last of the AW/W handshakes at cycle W gives `bready`=1 at W+1. `bvalid` at cycle B gives `done`=1, `busy`=0 at B+1.
- Minimum latency with slaves always ready: read `done` at S+3; write `done` at S+3.
- `start` may be accepted in the same cycle `done` is high, since `busy` is already 0.

## Test plan
- Read, addr=0x1000_0005, slave returns rdata=0x8877_6655_4433_2211 -> araddr=0x1000_0000; `data_read`=0x66; one `done` pulse; `busy` high S+1 through the cycle of `rvalid`.
- Write, addr=0x2000_0003, data_write=0xA5 -> awaddr=0x2000_0000, wstrb=0x08, wdata=0xA5A5_A5A5_A5A5_A5A5; `done` after `bvalid`.
- Write with `awready` delayed 3 cycles while `wready` is immediate -> `wvalid` drops after 1 cycle, `awvalid` is held; `bready` only after both handshakes.
- Read with rresp=2'b10 -> still completes: `done` pulses, byte captured, no hang.
- `start` pulsed while `busy` -> ignored: exactly one AR issued and one `done`.
- `aresetn`=0 during RD_DATA -> `rready`/`busy` go to 0, no `done`; the next `start` works normally.

Source files
------------

// File: rtl/axi_byte_io_master.sv
// Single-byte DMA master over a 64-bit AXI4-Lite port.
// One start pulse moves one byte between the channel and memory.
module axi_byte_io_master (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        busy,
    input  logic        write,
    input  logic [31:0] addr,
    output logic [7:0]  data_read,
    input  logic [7:0]  data_write,
    input  logic        start,
    output logic        done,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  lane_q, lane_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [7:0]  data_read_q, data_read_d;
    logic        done_q, done_d;
    logic        aw_ok_q, aw_ok_d;
    logic        w_ok_q, w_ok_d;
    logic        aw_hs, w_hs;

    // Responses carry no information this engine acts on.
    logic unused_resp;
    assign unused_resp = ^{m_axi_rresp, m_axi_bresp};

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign data_read     = data_read_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign m_axi_awvalid = (state_q == WR_REQ) && !aw_ok_q;
    assign m_axi_wvalid  = (state_q == WR_REQ) && !w_ok_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;

    assign aw_hs = aw_ok_q || m_axi_awready;
    assign w_hs  = w_ok_q || m_axi_wready;

    // Next-state, capture and completion logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        data_read_d = data_read_q;
        done_d      = 1'b0;
        aw_ok_d     = aw_ok_q;
        w_ok_d      = w_ok_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = {addr[31:3], 3'b000};
                    lane_d  = addr[2:0];
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    if (write) begin
                        wdata_d = {8{data_write}};
                        wstrb_d = 8'b1 << addr[2:0];
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    data_read_d = m_axi_rdata[{lane_q, 3'b000} +: 8];
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_REQ: begin
                aw_ok_d = aw_hs;
                w_ok_d  = w_hs;
                if (aw_hs && w_hs) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            data_read_q <= '0;
            done_q      <= 1'b0;
            aw_ok_q     <= 1'b0;
            w_ok_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            data_read_q <= data_read_d;
            done_q      <= done_d;
            aw_ok_q     <= aw_ok_d;
            w_ok_q      <= w_ok_d;
        end
    end

endmodule

// File: tb/tb_axi_byte_io_master.sv
// Bench for axi_byte_io_master: byte-addressed memory model
// behind a scripted AXI-Lite slave with random delays.
module tb_axi_byte_io_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        busy, write, start, done;
    logic [31:0] addr;
    logic [7:0]  data_read, data_write;
    logic [31:0] m_axi_araddr, m_axi_awaddr;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata, m_axi_wdata;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic        m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;

    axi_byte_io_master dut (
        .aclk(aclk), .aresetn(aresetn), .busy(busy), .write(write),
        .addr(addr), .data_read(data_read), .data_write(data_write),
        .start(start), .done(done),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] mem [bit [31:0]];

    always @(posedge aclk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3c;
    endfunction

    function automatic logic [63:0] line_rd(input logic [31:0] a);
        logic [63:0] v;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            b = {a[31:3], 3'b000} + 32'(i);
            v[8*i +: 8] = mem_rd(b);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_read(input logic [31:0] a, input int ar_dly,
                            input int r_dly, input logic [1:0] resp,
                            input bit spam);
        logic [7:0]  exp;
        logic [31:0] al;
        int n;
        bit ok;
        exp = mem_rd(a);
        al  = {a[31:3], 3'b000};
        start = 1; write = 0; addr = a; data_write = 8'($urandom);
        step();
        start = 0;
        checks++;
        if ({busy, m_axi_arvalid, done, m_axi_rready} !== 4'b1100) begin
            errors++;
            $display("FAIL rd_s1 busy/arv/done/rr got=%b exp=1100",
                     {busy, m_axi_arvalid, done, m_axi_rready});
        end
        checks++;
        if (m_axi_araddr !== al) begin
            errors++;
            $display("FAIL rd_araddr got=%h exp=%h", m_axi_araddr, al);
        end
        n = 0; ok = 0;
        while (!ok) begin
            if (spam) begin
                start = 1; write = 1'($urandom); addr = $urandom;
            end
            checks++;
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== al) begin
                errors++;
                $display("FAIL rd_ar_hold arv=%b addr=%h exp=1 %h",
                         m_axi_arvalid, m_axi_araddr, al);
            end
            m_axi_arready = (n >= ar_dly);
            ok = m_axi_arready && m_axi_arvalid;
            step();
            n++;
            if (n > ar_dly + 3) begin
                errors++;
                $display("FAIL rd_ar_timeout n=%0d exp<=%0d", n, ar_dly + 1);
                ok = 1;
            end
        end
        m_axi_arready = 0;
        checks++;
        if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin
            errors++;
            $display("FAIL rd_a1 arv/rr got=%b exp=01",
                     {m_axi_arvalid, m_axi_rready});
        end
        n = 0; ok = 0;
        while (!ok) begin
            if (spam) begin
                start = 1; write = 1'($urandom); addr = $urandom;
            end
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL rd_wait busy/done got=%b exp=10", {busy, done});
            end
            if (n >= r_dly) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = line_rd(a);
                m_axi_rresp  = resp;
                ok = m_axi_rready;
            end else begin
                m_axi_rvalid = 0;
                m_axi_rdata  = {$urandom, $urandom};
            end
            step();
            n++;
            if (n > r_dly + 3) begin
                errors++;
                $display("FAIL rd_r_timeout n=%0d", n);
                ok = 1;
            end
        end
        m_axi_rvalid = 0; m_axi_rresp = 0; start = 0;
        checks++;
        if ({done, busy, m_axi_rready} !== 3'b100) begin
            errors++;
            $display("FAIL rd_done done/busy/rr got=%b exp=100",
                     {done, busy, m_axi_rready});
        end
        checks++;
        if (data_read !== exp) begin
            errors++;
            $display("FAIL rd_data addr=%h got=%h exp=%h", a, data_read, exp);
        end
        last_rd = exp;
    endtask

    task automatic run_write(input logic [31:0] a, input logic [7:0] d,
                             input int aw_dly, input int w_dly,
                             input int b_dly);
        logic [31:0] al;
        logic [7:0]  strb;
        int n;
        bit aw_acc, w_acc, ok;
        al   = {a[31:3], 3'b000};
        strb = 8'h01 << a[2:0];
        start = 1; write = 1; addr = a; data_write = d;
        step();
        start = 0; data_write = 8'($urandom);
        checks++;
        if ({busy, m_axi_awvalid, m_axi_wvalid, done} !== 4'b1110) begin
            errors++;
            $display("FAIL wr_s1 busy/awv/wv/done got=%b exp=1110",
                     {busy, m_axi_awvalid, m_axi_wvalid, done});
        end
        checks++;
        if (m_axi_awaddr !== al || m_axi_wstrb !== strb ||
            m_axi_wdata !== {8{d}}) begin
            errors++;
            $display("FAIL wr_bus aw=%h st=%h wd=%h exp=%h %h %h",
                     m_axi_awaddr, m_axi_wstrb, m_axi_wdata,
                     al, strb, {8{d}});
        end
        n = 0; aw_acc = 0; w_acc = 0;
        while (!(aw_acc && w_acc)) begin
            checks++;
            if (m_axi_awvalid !== !aw_acc || m_axi_wvalid !== !w_acc ||
                m_axi_bready !== 1'b0) begin
                errors++;
                $display("FAIL wr_req awv=%b wv=%b br=%b exp=%b %b 0",
                         m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         !aw_acc, !w_acc);
            end
            m_axi_awready = (n >= aw_dly);
            m_axi_wready  = (n >= w_dly);
            if (m_axi_awready && m_axi_awvalid) aw_acc = 1;
            if (m_axi_wready && m_axi_wvalid) w_acc = 1;
            step();
            n++;
            if (n > aw_dly + w_dly + 3) begin
                errors++;
                $display("FAIL wr_req_timeout n=%0d", n);
                aw_acc = 1; w_acc = 1;
            end
        end
        m_axi_awready = 0; m_axi_wready = 0;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            errors++;
            $display("FAIL wr_w1 awv/wv/br got=%b exp=001",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        end
        n = 0; ok = 0;
        while (!ok) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL wr_wait busy/done got=%b exp=10", {busy, done});
            end
            m_axi_bvalid = (n >= b_dly);
            m_axi_bresp  = 2'($urandom);
            ok = m_axi_bvalid && m_axi_bready;
            step();
            n++;
            if (n > b_dly + 3) begin
                errors++;
                $display("FAIL wr_b_timeout n=%0d", n);
                ok = 1;
            end
        end
        m_axi_bvalid = 0;
        checks++;
        if ({done, busy, m_axi_bready} !== 3'b100) begin
            errors++;
            $display("FAIL wr_done done/busy/br got=%b exp=100",
                     {done, busy, m_axi_bready});
        end
        checks++;
        if (data_read !== last_rd) begin
            errors++;
            $display("FAIL wr_keeps_rd got=%h exp=%h", data_read, last_rd);
        end
        mem[a] = d;
    endtask

    task automatic test_reset();
        aresetn = 0;
        step();
        step();
        checks++;
        if ({busy, done, data_read, m_axi_arvalid, m_axi_rready,
             m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 15'd0) begin
            errors++;
            $display("FAIL reset_ctl got=%h exp=0",
                     {busy, done, data_read, m_axi_arvalid, m_axi_rready,
                      m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        end
        checks++;
        if ({m_axi_araddr, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== 136'd0)
        begin
            errors++;
            $display("FAIL reset_bus ar=%h aw=%h wd=%h st=%h exp=0",
                     m_axi_araddr, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
        end
        aresetn = 1;
        step();
    endtask

    task automatic test_read_plan();
        for (int i = 0; i < 8; i++) mem[32'h1000_0000 + 32'(i)] = 8'(8'h11 * (i + 1));
        run_read(32'h1000_0005, 0, 0, 2'b00, 0);
        checks++;
        if (data_read !== 8'h66) begin
            errors++;
            $display("FAIL read_plan got=%h exp=66", data_read);
        end
        step();
    endtask

    task automatic test_write_plan();
        run_write(32'h2000_0003, 8'hA5, 0, 0, 0);
        step();
        run_read(32'h2000_0003, 0, 1, 2'b00, 0);
        step();
    endtask

    task automatic test_aw_delay();
        run_write(32'h2000_0016, 8'h3C, 3, 0, 1);
        step();
        run_write(32'h2000_0011, 8'hC3, 0, 2, 0);
        step();
        run_read(32'h2000_0016, 2, 0, 2'b00, 0);
        step();
    endtask

    task automatic test_rresp_err();
        int c0;
        c0 = done_cnt;
        run_read(32'h1000_0002, 1, 2, 2'b10, 0);
        step();
        checks++;
        if (done_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL rresp_done_cnt got=%0d exp=1", done_cnt - c0);
        end
    endtask

    task automatic test_busy_ignore();
        int c0;
        c0 = done_cnt;
        run_read(32'h1000_0007, 2, 3, 2'b00, 1);
        step();
        checks++;
        if ({busy, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_second_start got=%b exp=0000",
                     {busy, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid});
        end
        checks++;
        if (done_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL ignore_done_cnt got=%0d exp=1", done_cnt - c0);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = done_cnt;
        start = 1; write = 0; addr = 32'h1000_0004;
        step();
        start = 0; m_axi_arready = 1;
        step();
        m_axi_arready = 0;
        checks++;
        if (m_axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre rr got=%b exp=1", m_axi_rready);
        end
        aresetn = 0;
        step();
        aresetn = 1;
        checks++;
        if ({m_axi_rready, busy, done, m_axi_arvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid rr/busy/done/arv got=%b exp=0000",
                     {m_axi_rready, busy, done, m_axi_arvalid});
        end
        step();
        step();
        checks++;
        if (done_cnt - c0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_done cnt=%0d busy=%b exp=0 0",
                     done_cnt - c0, busy);
        end
        last_rd = 8'h00;
        run_read(32'h1000_0004, 0, 0, 2'b00, 0);
        step();
    endtask

    task automatic test_back_to_back();
        run_read(32'h1000_0001, 0, 0, 2'b00, 0);
        run_write(32'h1000_0001, 8'h5A, 0, 0, 0);
        run_read(32'h1000_0001, 0, 0, 2'b01, 0);
        step();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = 32'h3000_0000 | 32'($urandom_range(0, 23));
            if ($urandom_range(0, 1) == 1)
                run_write(a, 8'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                run_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                         2'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    initial begin
        start = 0; write = 0; addr = 0; data_write = 0;
        m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bresp = 0; m_axi_bvalid = 0;
        test_reset();
        test_read_plan();
        test_write_plan();
        test_aw_delay();
        test_rresp_err();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
